// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RV32 funct3 codes, access-size decode and alignment helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size of a funct3 code; reserved codes behave as word accesses.
  function automatic lsu_size_t f3_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  // A halfword on an odd byte or a word off a word boundary is misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a);
    case (f3_size(funct3))
      SZ_HALF: return a[0];
      SZ_WORD: return |a;
      default: return 1'b0;
    endcase
  endfunction

  // Byte-lane offset with the low bits forced to the natural alignment of the access.
  function automatic logic [1:0] align_offset(input logic [2:0] funct3, input logic [1:0] a);
    case (f3_size(funct3))
      SZ_BYTE: return a;
      SZ_HALF: return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Purely combinational byte-lane steering for the load/store unit:
// merges store data into an old memory word, and extracts/extends a load
// result from a memory word. The offset is expected already aligned.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_merged_word,
  output logic [31:0] o_load_result
);

  lsu_size_t   w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size = f3_size(i_funct3);
  assign w_byte = i_load_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_load_word[{i_offset[1], 4'b0000} +: 16];

  // Store merge: replace only the lanes covered by the access.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    o_merged_word = i_old_word;
    case (w_size)
      SZ_BYTE: o_merged_word[{i_offset, 3'b000} +: 8]     = i_store_data[7:0];
      SZ_HALF: o_merged_word[{i_offset[1], 4'b0000} +: 16] = i_store_data[15:0];
      default: o_merged_word = i_store_data;
    endcase
  end

  // Load extract: funct3[2] selects zero-extension (BU/HU) over sign-extension.
  always_comb begin
    o_load_result = i_load_word;
    case (w_size)
      SZ_BYTE: o_load_result = i_funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_load_result = i_funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_load_result = i_load_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RV32 loads/stores into word reads
// and merged word writes on a single-port, word-addressed data memory.
// Sub-word stores use read-modify-write. Optional macro
// LSU_MISALIGN_TRAP_EN makes misaligned accesses return resp_error instead
// of being silently aligned down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_address,
  input  logic [DATA_WIDTH-1:0]    req_write_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_read_data,
  output logic                     resp_error,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     mem_write_enable,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  lsu_state_t            r_state;
  lsu_state_t            w_next_state;
  logic                  r_store;
  logic [2:0]            r_funct3;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_error;

  logic                  w_accept;
  logic                  w_req_trap;
  logic [1:0]            w_req_offset;
  logic [DATA_WIDTH-1:0] w_merged_word;
  logic [DATA_WIDTH-1:0] w_load_result;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_req_trap = is_misaligned(req_funct3, req_address[1:0]);
`else
  assign w_req_trap = 1'b0;
`endif

  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_req_offset = align_offset(req_funct3, req_address[1:0]);

  lsu_lane_align u_lane_align (
    .i_old_word    (r_rdata),
    .i_store_data  (r_wdata),
    .i_load_word   (mem_read_data),
    .i_offset      (r_addr[1:0]),
    .i_funct3      (r_funct3),
    .o_merged_word (w_merged_word),
    .o_load_result (w_load_result)
  );

  // Outputs decoded from state; reset forces IDLE, which kills any write strobe at once.
  assign req_ready        = (r_state == IDLE);
  assign resp_valid       = (r_state == RESP);
  assign resp_read_data   = r_resp_data;
  assign resp_error       = (r_state == RESP) && r_error;
  assign mem_address      = r_addr[ADDRESS_WIDTH+1:2];
  assign mem_write_enable = (r_state == WRITE);
  assign mem_write_data   = (r_state == WRITE) ? w_merged_word : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state: loads and sub-word stores read first, full-word stores write directly.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_req_trap)                           w_next_state = RESP;
          else if (!req_store)                      w_next_state = READ;
          else if (f3_size(req_funct3) == SZ_WORD)  w_next_state = WRITE;
          else                                      w_next_state = READ;
        end
      end
      READ:    w_next_state = r_store ? WRITE : RESP;
      WRITE:   w_next_state = RESP;
      RESP:    if (resp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch on accept and read-data capture in READ.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data registers are cleared too because the memory-side and response outputs derive from them.
    if (rst) begin
      r_store     <= 1'b0;
      r_funct3    <= F3_W;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_resp_data <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_store     <= req_store;
            r_funct3    <= req_funct3;
            r_addr      <= {req_address[31:2], w_req_offset};
            r_wdata     <= req_write_data;
            r_resp_data <= '0;
            r_error     <= w_req_trap;
          end
        end
        READ: begin
          r_rdata     <= mem_read_data;
          r_resp_data <= r_store ? '0 : w_load_result;
        end
        default: ;
      endcase
    end
  end

endmodule
